// File: rtl/div.sv
// Multi-cycle 32-bit restoring divider for the EX stage: signed or unsigned,
// producing {remainder, quotient} after 33 cycles, or zero immediately for a divide by zero.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   FREE   | idle, waiting for start_i; outputs held at zero
//   BYZERO | divisor was zero; next edge publishes a zero result
//   ON     | one shift-subtract iteration per edge, sign fix on the last
//   END    | result valid; held until start_i drops
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic        r_signed;
    logic [31:0] r_quot;
    logic [31:0] r_rem;
    logic [31:0] r_dsr;
    logic [63:0] r_result;
    logic        r_ready;

    state_t      w_state;
    logic [5:0]  w_cnt;
    logic [31:0] w_op1;
    logic [31:0] w_op2;
    logic        w_signed;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_dsr;
    logic [63:0] w_result;
    logic        w_ready;

    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic [32:0] w_rem_sh;
    logic [33:0] w_diff;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    // Magnitudes are taken from the live inputs because they are only used at the sample edge.
    assign w_mag1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign w_mag2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

    // Partial remainder can reach 33 bits after the shift; a borrow means "restore".
    assign w_rem_sh = {r_rem, r_quot[31]};
    assign w_diff   = {1'b0, w_rem_sh} - {2'b00, r_dsr};

    assign w_q_fix = (r_signed && (r_op1[31] ^ r_op2[31])) ? (~r_quot + 32'd1) : r_quot;
    assign w_r_fix = (r_signed && r_op1[31]) ? (~r_rem + 32'd1) : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= FREE;
            r_cnt    <= 6'd0;
            r_op1    <= 32'd0;
            r_op2    <= 32'd0;
            r_signed <= 1'b0;
            r_quot   <= 32'd0;
            r_rem    <= 32'd0;
            r_dsr    <= 32'd0;
            r_result <= 64'd0;
            r_ready  <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_op1    <= w_op1;
            r_op2    <= w_op2;
            r_signed <= w_signed;
            r_quot   <= w_quot;
            r_rem    <= w_rem;
            r_dsr    <= w_dsr;
            r_result <= w_result;
            r_ready  <= w_ready;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_op1    = r_op1;
        w_op2    = r_op2;
        w_signed = r_signed;
        w_quot   = r_quot;
        w_rem    = r_rem;
        w_dsr    = r_dsr;
        w_result = r_result;
        w_ready  = r_ready;

        case (r_state)
            FREE: begin
                w_ready  = 1'b0;
                w_result = 64'd0;
                w_cnt    = 6'd0;
                if (start_i && !annul_i) begin
                    w_op1    = opdata1_i;
                    w_op2    = opdata2_i;
                    w_signed = signed_div_i;
                    w_quot   = w_mag1;
                    w_rem    = 32'd0;
                    w_dsr    = w_mag2;
                    w_state  = (opdata2_i == 32'd0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                if (annul_i) begin
                    w_state = FREE;
                    w_cnt   = 6'd0;
                end else begin
                    w_state  = END;
                    w_result = 64'd0;
                    w_ready  = 1'b1;
                end
            end
            ON: begin
                if (annul_i) begin
                    w_state = FREE;
                    w_cnt   = 6'd0;
                end else if (r_cnt == 6'd32) begin
                    w_result = {w_r_fix, w_q_fix};
                    w_ready  = 1'b1;
                    w_state  = END;
                end else begin
                    if (w_diff[33]) begin
                        w_rem  = w_rem_sh[31:0];
                        w_quot = {r_quot[30:0], 1'b0};
                    end else begin
                        w_rem  = w_diff[31:0];
                        w_quot = {r_quot[30:0], 1'b1};
                    end
                    w_cnt = r_cnt + 6'd1;
                end
            end
            END: begin
                if (!start_i) begin
                    w_state  = FREE;
                    w_ready  = 1'b0;
                    w_result = 64'd0;
                end
            end
            default: begin
                w_state  = FREE;
                w_ready  = 1'b0;
                w_result = 64'd0;
                w_cnt    = 6'd0;
            end
        endcase
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule

// File: tb/tb_div.sv
// Directed bench for div: hand-computed quotient/remainder vectors plus
// divide-by-zero, annul, mid-operation reset and the overflow corner.
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_checks;
    int n_fail;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Start at E0, scramble operand inputs during the run, expect the result at E<lat>,
    // hold it (also across an ignored annul), then release with start_i=0.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int lat);
        int early;
        early        = 0;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        tick;
        opdata1_i    = ~a;
        opdata2_i    = b ^ 32'h0000_5A5A;
        signed_div_i = ~sgn;
        for (int k = 1; k < lat; k++) begin
            tick;
            if (ready_o !== 1'b0 || result_o !== 64'd0) early++;
        end
        chk({tag, " early_ready"}, 64'(early), 64'd0);
        tick;
        chk({tag, " ready"}, 64'(ready_o), 64'd1);
        chk({tag, " result"}, result_o, exp);
        annul_i = 1'b1;
        tick;
        annul_i = 1'b0;
        chk({tag, " hold"}, {result_o[62:0], ready_o}, {exp[62:0], 1'b1});
        start_i = 1'b0;
        tick;
        chk({tag, " release"}, {63'd0, ready_o} | result_o, 64'd0);
    endtask

    initial begin
        int early;
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        tick;
        tick;
        chk("reset ready", 64'(ready_o), 64'd0);
        chk("reset result", result_o, 64'd0);
        rst = 1'b0;
        tick;

        run_div("u100_7",   1'b0, 32'd100,       32'd7,          {32'd2, 32'd14}, 33);
        run_div("s-7_2",    1'b1, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        run_div("u-7_2",    1'b0, 32'hFFFF_FFF9, 32'h0000_0002, {32'h0000_0001, 32'h7FFF_FFFC}, 33);
        run_div("s7_-2",    1'b1, 32'd7,         32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
        run_div("s-8_-3",   1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, {32'hFFFF_FFFE, 32'h0000_0002}, 33);
        run_div("u_max_1",  1'b0, 32'hFFFF_FFFF, 32'd1,         {32'd0, 32'hFFFF_FFFF}, 33);
        run_div("u_small",  1'b0, 32'd3,         32'd10,        {32'd3, 32'd0}, 33);
        run_div("s_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
        run_div("s5_0",     1'b1, 32'd5,         32'd0,         64'd0, 1);

        // Annul at E10 of 1000/3; restart 9/3 at E12, expect {0,3} at E45.
        early        = 0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        tick;
        for (int e = 1; e <= 44; e++) begin
            annul_i = (e == 10 || e == 11);
            if (e == 12) begin
                opdata1_i = 32'd9;
                opdata2_i = 32'd3;
            end
            tick;
            if (ready_o !== 1'b0 || result_o !== 64'd0) early++;
        end
        annul_i = 1'b0;
        chk("annul quiet", 64'(early), 64'd0);
        tick;
        chk("annul restart ready", 64'(ready_o), 64'd1);
        chk("annul restart result", result_o, {32'd0, 32'd3});
        start_i = 1'b0;
        tick;
        chk("annul release", 64'(ready_o), 64'd0);

        // Reset at E20 of a running division; start still high, so E21 accepts 12345/100.
        early     = 0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        tick;
        for (int e = 1; e < 20; e++) tick;
        rst = 1'b1;
        tick;
        chk("rst mid ready", 64'(ready_o), 64'd0);
        chk("rst mid result", result_o, 64'd0);
        rst       = 1'b0;
        opdata1_i = 32'd12345;
        opdata2_i = 32'd100;
        tick;
        for (int e = 1; e < 33; e++) begin
            tick;
            if (ready_o !== 1'b0 || result_o !== 64'd0) early++;
        end
        chk("rst after quiet", 64'(early), 64'd0);
        tick;
        chk("rst after ready", 64'(ready_o), 64'd1);
        chk("rst after result", result_o, {32'd45, 32'd123});
        start_i = 1'b0;
        tick;
        chk("rst after release", {63'd0, ready_o} | result_o, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
